// File: rtl/instr_sequencer_if.sv
// Control bundle between the multi-cycle sequencer and the rest of the core.
// The master side drives instruction status and the memory ack; the slave side is the sequencer.
interface instr_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             Start;
   logic [3:0]       Opcode;
   logic             Zero;
   logic             Halt;
   logic             MemAck;
   logic             IRLoad;
   logic             PCEn;
   logic             BranchTaken;
   logic             RegWriteEn;
   logic             MemReadEn;
   logic             MemWriteEn;
   logic             Done;
   logic             Error;
   logic [2:0]       State;
   logic [CNT_W-1:0] CycleCount;
   logic [CNT_W-1:0] InstrCount;

   modport master (
      output Start, Opcode, Zero, Halt, MemAck,
      input  IRLoad, PCEn, BranchTaken, RegWriteEn, MemReadEn, MemWriteEn,
      input  Done, Error, State, CycleCount, InstrCount
   );

   modport slave (
      input  Start, Opcode, Zero, Halt, MemAck,
      output IRLoad, PCEn, BranchTaken, RegWriteEn, MemReadEn, MemWriteEn,
      output Done, Error, State, CycleCount, InstrCount
   );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer with retire strobe, memory wait timeout
// and saturating cycle / retired-instruction counters.
module instr_sequencer #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 8
) (
   input logic              Clk,
   input logic              Reset,
   instr_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      EXEC  = 3'd2,
      MEM   = 3'd3,
      WB    = 3'd4,
      HALT  = 3'd5,
      ERR   = 3'd6
   } stateT;

   localparam int               WAIT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   stateT             state;
   stateT             nextState;
   logic [WAIT_W-1:0] waitCnt;
   logic [CNT_W-1:0]  cycleCount;
   logic [CNT_W-1:0]  instrCount;

   logic isLoad;
   logic isStore;
   logic isBne;
   logic active;

   logic irLoad;
   logic pcEn;
   logic branchTaken;
   logic regWriteEn;
   logic memReadEn;
   logic memWriteEn;

   assign isLoad  = (bus.Opcode[3:1] == 3'b011);
   assign isStore = (bus.Opcode[3:1] == 3'b100);
   assign isBne   = (bus.Opcode == 4'b1100);
   assign active  = (state == FETCH) || (state == EXEC) || (state == MEM) || (state == WB);

   // Memory handshake: MemReadEn/MemWriteEn is a request held high every MEM cycle
   // until MemAck is seen in the same cycle; that cycle completes the access.
   always_comb begin
      nextState   = state;
      irLoad      = 1'b0;
      pcEn        = 1'b0;
      branchTaken = 1'b0;
      regWriteEn  = 1'b0;
      memReadEn   = 1'b0;
      memWriteEn  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.Start) nextState = FETCH;
         end
         FETCH: begin
            irLoad    = 1'b1;
            nextState = EXEC;
         end
         EXEC: begin
            if (isBne) begin
               pcEn        = 1'b1;
               branchTaken = ~bus.Zero;
               nextState   = bus.Halt ? HALT : FETCH;
            end else if (isLoad || isStore) begin
               nextState = MEM;
            end else begin
               nextState = WB;
            end
         end
         MEM: begin
            memReadEn  = isLoad;
            memWriteEn = isStore;
            // An ack in the final allowed cycle still completes the access.
            if (bus.MemAck) begin
               if (isLoad) begin
                  nextState = WB;
               end else begin
                  pcEn      = 1'b1;
                  nextState = bus.Halt ? HALT : FETCH;
               end
            end else if (waitCnt == WAIT_LAST) begin
               nextState = ERR;
            end
         end
         WB: begin
            regWriteEn = 1'b1;
            pcEn       = 1'b1;
            nextState  = bus.Halt ? HALT : FETCH;
         end
         HALT: nextState = HALT;
         ERR:  nextState = ERR;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state      <= IDLE;
         waitCnt    <= '0;
         cycleCount <= '0;
         instrCount <= '0;
      end else begin
         state <= nextState;
         // Outside MEM the counter sits at zero, so it is already clear on MEM entry.
         if ((state == MEM) && !bus.MemAck) waitCnt <= waitCnt + 1'b1;
         else                               waitCnt <= '0;
         if (active && (cycleCount != CNT_MAX)) cycleCount <= cycleCount + 1'b1;
         if (pcEn && (instrCount != CNT_MAX))   instrCount <= instrCount + 1'b1;
      end
   end

   assign bus.IRLoad      = irLoad;
   assign bus.PCEn        = pcEn;
   assign bus.BranchTaken = branchTaken;
   assign bus.RegWriteEn  = regWriteEn;
   assign bus.MemReadEn   = memReadEn;
   assign bus.MemWriteEn  = memWriteEn;
   assign bus.Done        = (state == HALT);
   assign bus.Error       = (state == ERR);
   assign bus.State       = state;
   assign bus.CycleCount  = cycleCount;
   assign bus.InstrCount  = instrCount;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle expected output words go through a
// queue and are checked against the DUT at the falling edge.
module tb_instr_sequencer;
   localparam logic [7:0] IRL  = 8'h80;
   localparam logic [7:0] PCE  = 8'h40;
   localparam logic [7:0] BRT  = 8'h20;
   localparam logic [7:0] RWE  = 8'h10;
   localparam logic [7:0] MRE  = 8'h08;
   localparam logic [7:0] MWE  = 8'h04;
   localparam logic [7:0] DNE  = 8'h02;
   localparam logic [7:0] ERRF = 8'h01;

   logic Clk;
   logic Reset1;
   logic Reset2;
   int   checks;
   int   errors;
   logic [10:0] exp_q[$];

   instr_sequencer_if #(.CNT_W(16)) bus1();
   instr_sequencer_if #(.CNT_W(4))  bus2();

   instr_sequencer #(.CNT_W(16), .MEM_TIMEOUT(8)) dut1 (
      .Clk(Clk), .Reset(Reset1), .bus(bus1)
   );
   instr_sequencer #(.CNT_W(4), .MEM_TIMEOUT(8)) dut2 (
      .Clk(Clk), .Reset(Reset2), .bus(bus2)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [10:0] ex(input logic [2:0] st, input logic [7:0] fl);
      return {st, fl};
   endfunction

   function automatic logic [10:0] obs1();
      return {bus1.State, bus1.IRLoad, bus1.PCEn, bus1.BranchTaken, bus1.RegWriteEn,
              bus1.MemReadEn, bus1.MemWriteEn, bus1.Done, bus1.Error};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs are set before the call; outputs are sampled mid-cycle, then the edge is taken.
   task automatic cyc(input string tag, input logic [10:0] e);
      logic [10:0] want;
      exp_q.push_back(e);
      @(negedge Clk);
      want = exp_q.pop_front();
      chk(tag, 16'(obs1()), 16'(want));
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset1 = 1'b0;
      bus1.Start = 1'b0; bus1.Halt = 1'b0; bus1.MemAck = 1'b0; bus1.Zero = 1'b0;
      @(posedge Clk);
      #1;
      Reset1 = 1'b1;
   endtask

   initial begin
      logic done2;
      checks = 0;
      errors = 0;
      Reset1 = 1'b0;
      Reset2 = 1'b0;
      bus1.Start = 1'b0; bus1.Opcode = 4'h0; bus1.Zero = 1'b0; bus1.Halt = 1'b0; bus1.MemAck = 1'b0;
      bus2.Start = 1'b0; bus2.Opcode = 4'h0; bus2.Zero = 1'b0; bus2.Halt = 1'b0; bus2.MemAck = 1'b0;
      repeat (2) @(posedge Clk);
      #1;

      // Reset state
      cyc("rst_idle", ex(3'd0, 8'h00));
      chk("rst_cycles", bus1.CycleCount, 16'd0);
      chk("rst_instrs", bus1.InstrCount, 16'd0);
      Reset1 = 1'b1;

      // ALU ops, Halt only honoured at retire of the second one
      bus1.Start = 1'b1; bus1.Opcode = 4'b0000;
      cyc("alu_idle", ex(3'd0, 8'h00));
      bus1.Halt = 1'b1;
      cyc("alu_f1", ex(3'd1, IRL));
      cyc("alu_e1", ex(3'd2, 8'h00));
      bus1.Halt = 1'b0;
      cyc("alu_wb1", ex(3'd4, RWE | PCE));
      cyc("alu_f2", ex(3'd1, IRL));
      cyc("alu_e2", ex(3'd2, 8'h00));
      bus1.Halt = 1'b1;
      cyc("alu_wb2", ex(3'd4, RWE | PCE));
      cyc("alu_halt", ex(3'd5, DNE));
      chk("alu_instrs", bus1.InstrCount, 16'd2);
      chk("alu_cycles", bus1.CycleCount, 16'd6);
      cyc("alu_halt_start", ex(3'd5, DNE));

      // bne not taken / taken
      do_reset();
      bus1.Start = 1'b1; bus1.Opcode = 4'b1100; bus1.Zero = 1'b0;
      cyc("bne_idle", ex(3'd0, 8'h00));
      cyc("bne_f1", ex(3'd1, IRL));
      cyc("bne_e1", ex(3'd2, PCE | BRT));
      bus1.Zero = 1'b1; bus1.Halt = 1'b1;
      cyc("bne_f2", ex(3'd1, IRL));
      cyc("bne_e2", ex(3'd2, PCE));
      cyc("bne_halt", ex(3'd5, DNE));
      chk("bne_instrs", bus1.InstrCount, 16'd2);
      chk("bne_cycles", bus1.CycleCount, 16'd4);

      // load with three wait cycles; an early ack outside MEM is ignored
      do_reset();
      bus1.Start = 1'b1; bus1.Opcode = 4'b0110;
      cyc("ld_idle", ex(3'd0, 8'h00));
      cyc("ld_f", ex(3'd1, IRL));
      bus1.MemAck = 1'b1;
      cyc("ld_e", ex(3'd2, 8'h00));
      bus1.MemAck = 1'b0;
      for (int i = 0; i < 3; i++) cyc("ld_mem_wait", ex(3'd3, MRE));
      bus1.MemAck = 1'b1;
      cyc("ld_mem_ack", ex(3'd3, MRE));
      bus1.MemAck = 1'b0; bus1.Halt = 1'b1;
      cyc("ld_wb", ex(3'd4, RWE | PCE));
      cyc("ld_halt", ex(3'd5, DNE));
      chk("ld_cycles", bus1.CycleCount, 16'd7);
      chk("ld_instrs", bus1.InstrCount, 16'd1);

      // store timeout
      do_reset();
      bus1.Start = 1'b1; bus1.Opcode = 4'b1000;
      cyc("st_idle", ex(3'd0, 8'h00));
      cyc("st_f", ex(3'd1, IRL));
      cyc("st_e", ex(3'd2, 8'h00));
      for (int i = 0; i < 8; i++) cyc("st_mem_wait", ex(3'd3, MWE));
      cyc("st_err", ex(3'd6, ERRF));
      bus1.MemAck = 1'b1; bus1.Halt = 1'b1;
      cyc("st_err_held", ex(3'd6, ERRF));
      chk("st_err_cycles", bus1.CycleCount, 16'd10);
      chk("st_err_instrs", bus1.InstrCount, 16'd0);
      Reset1 = 1'b0;
      cyc("st_err_rst", ex(3'd6, ERRF));
      Reset1 = 1'b1; bus1.Start = 1'b0; bus1.MemAck = 1'b0; bus1.Halt = 1'b0;
      cyc("st_err_cleared", ex(3'd0, 8'h00));

      // store acked in the last allowed cycle, then a zero-wait store
      bus1.Start = 1'b1;
      cyc("sb_idle", ex(3'd0, 8'h00));
      cyc("sb_f1", ex(3'd1, IRL));
      cyc("sb_e1", ex(3'd2, 8'h00));
      for (int i = 0; i < 7; i++) cyc("sb_mem_wait", ex(3'd3, MWE));
      bus1.MemAck = 1'b1;
      cyc("sb_mem_ack_last", ex(3'd3, MWE | PCE));
      bus1.MemAck = 1'b0;
      cyc("sb_f2", ex(3'd1, IRL));
      cyc("sb_e2", ex(3'd2, 8'h00));
      bus1.MemAck = 1'b1; bus1.Halt = 1'b1;
      cyc("sb_mem_ack_w0", ex(3'd3, MWE | PCE));
      bus1.MemAck = 1'b0;
      cyc("sb_halt", ex(3'd5, DNE));
      chk("sb_cycles", bus1.CycleCount, 16'd13);
      chk("sb_instrs", bus1.InstrCount, 16'd2);

      // reset in the middle of a pending load
      do_reset();
      bus1.Start = 1'b1; bus1.Opcode = 4'b0110;
      cyc("ab_idle", ex(3'd0, 8'h00));
      cyc("ab_f", ex(3'd1, IRL));
      cyc("ab_e", ex(3'd2, 8'h00));
      cyc("ab_mem1", ex(3'd3, MRE));
      Reset1 = 1'b0;
      cyc("ab_mem2", ex(3'd3, MRE));
      Reset1 = 1'b1; bus1.Start = 1'b0;
      cyc("ab_after", ex(3'd0, 8'h00));
      chk("ab_cycles", bus1.CycleCount, 16'd0);
      chk("ab_instrs", bus1.InstrCount, 16'd0);
      bus1.Start = 1'b1; bus1.Opcode = 4'b0000;
      cyc("ab_restart_idle", ex(3'd0, 8'h00));
      cyc("ab_restart_f", ex(3'd1, IRL));
      cyc("ab_restart_e", ex(3'd2, 8'h00));

      // counter saturation on the narrow instance: six set instructions
      Reset2 = 1'b1;
      bus2.Opcode = 4'b1101; bus2.Start = 1'b1; bus2.Halt = 1'b0;
      done2 = 1'b0;
      for (int i = 0; i < 40 && !done2; i++) begin
         @(negedge Clk);
         if (bus2.Done) done2 = 1'b1;
         else if (bus2.PCEn && (bus2.InstrCount == 4'd5)) bus2.Halt = 1'b1;
      end
      chk("sat_done", 16'(bus2.Done), 16'd1);
      chk("sat_cycles", 16'(bus2.CycleCount), 16'd15);
      chk("sat_instrs", 16'(bus2.InstrCount), 16'd6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

- Multi-cycle sequencer for the single-issue core.
- Steps each instruction through fetch, execute, memory and writeback phases, using the 4-bit opcode that also feeds the control decoder.
- Drives the PC, instruction-register, register-file and data-memory enables, and handles the data-memory ready handshake.
- Keeps cycle and retired-instruction counters and reports halt and memory-timeout status to the test harness.

## Interface

Parameters:
- CNT_W, 16, width of CycleCount and InstrCount
- MEM_TIMEOUT, 8, maximum MEM-state cycles without MemAck before error (≥1)

Ports:
- Clk  in  1  clock; all state changes on rising edge
- Reset  in  1  synchronous, active-low reset
- Start  in  1  begin execution from IDLE
- Opcode  in  4  instr[8:5] from instruction register; stable from EXEC until retire
- Zero  in  1  ALU equality flag, valid in EXEC
- Halt  in  1  current instruction is the last one; sampled in the retire cycle
- MemAck  in  1  data memory completed the current access
- IRLoad  out  1  load instruction register
- PCEn  out  1  advance PC (retire strobe)
- BranchTaken  out  1  PC takes branch target; valid only with PCEn
- RegWriteEn  out  1  register-file write strobe
- MemReadEn  out  1  data-memory read request
- MemWriteEn  out  1  data-memory write request
- Done  out  1  program halted
- Error  out  1  memory timeout, sticky
- State  out  3  current state encoding
- CycleCount  out  CNT_W  active cycles
- InstrCount  out  CNT_W  retired instructions

## Operation

- State encoding: IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6. Value 7 is illegal and recovers to IDLE on the next edge.
- Opcode classes use Opcode[3:1]:
  - 011 = load; 100 = store.
  - 110 with Opcode[0]=0 is bne; 1101 = set.
  - All other values are ALU ops.
- IDLE: all strobes 0. Start=1 → FETCH.
- FETCH: IRLoad=1 → EXEC.
- EXEC:
  - bne: PCEn=1, BranchTaken=~Zero. Goes to HALT if Halt=1, else FETCH.
  - load/store → MEM.
  - Otherwise → WB.
- MEM:
  - Request is held every cycle until acknowledged: MemReadEn=1 for load, MemWriteEn=1 for store.
  - On MemAck=1: load → WB; store asserts PCEn=1 that cycle → HALT if Halt=1, else FETCH.
  - A wait counter clears on MEM entry and increments each MEM cycle with MemAck=0. Reaching MEM_TIMEOUT → ERR.
- WB: RegWriteEn=1, PCEn=1 → HALT if Halt=1, else FETCH.
- HALT: Done=1, all strobes 0. Held until reset; Start is ignored.
- ERR: Error=1, all strobes 0. Held until reset.
- Output timing: strobes are combinational from the registered state plus Opcode/Zero/MemAck. Done, Error and State come from state only.
- Counters:
  - CycleCount increments every cycle spent in FETCH, EXEC, MEM or WB.
  - InstrCount increments on every cycle with PCEn=1.
  - Both saturate at 2^CNT_W−1; they do not wrap.
- RegWriteEn is never asserted for store or bne, and is never asserted in the same cycle as MemWriteEn.

## Timing

- Reset=0 at an edge:
  - State=IDLE; both counters and the wait counter = 0.
  - Done=0, Error=0; all strobes 0.
  - Reset mid-instruction aborts it with no further strobes.
- Cycles per instruction from FETCH to retire, inclusive:
  - ALU/set: 3.
  - bne: 2.
  - store: 3 + W.
  - load: 4 + W.
  - W = MEM cycles with MemAck=0.
- MemAck in the first MEM cycle gives W=0. MemAck outside MEM is ignored.
- MemAck arriving in the same cycle the wait count would reach MEM_TIMEOUT: the ack wins and there is no error.
- Halt is sampled only in the PCEn cycle. Halt in other cycles has no effect.
- Start held high through a full program has no effect after the IDLE exit.

## Test plan

- ALU op (opcode 0000), Halt=0, then Halt=1 on the second instruction:
  - States 1,2,4,1,2,4,5.
  - RegWriteEn pulses in cycles 3 and 6; Done=1 from cycle 7.
  - InstrCount=2, CycleCount=6.
- bne (1100) with Zero=0, then Zero=1:
  - The first retire has PCEn=1 with BranchTaken=1; the second has BranchTaken=0.
  - No RegWriteEn; 2 cycles each.
- Load (0110) with MemAck delayed 3 cycles:
  - MemReadEn high for 4 consecutive cycles, then WB with RegWriteEn=1.
  - CycleCount=7 at retire.
- Store (1000) with MemAck=0 for MEM_TIMEOUT=8 cycles:
  - State=ERR and Error=1 after 8 MEM cycles; MemWriteEn=0 afterwards.
  - Error stays set until Reset=0.
- Reset=0 asserted during MEM of a load with MemAck pending:
  - Next cycle State=IDLE, counters 0, no RegWriteEn.
  - Start restarts cleanly at FETCH.
- CNT_W=4, 6 ALU instructions: CycleCount saturates at 15; InstrCount reaches 6.
